// File: rtl/gng_clt.sv
// gng_clt: CLT Gaussian noise generator over a 3-component Tausworthe source, with a show-ahead output FIFO.
// Optional saturation event counter enabled by defining GNG_CLT_SAT_CNT_EN; otherwise sat_cnt reads 0.
module gng_clt #(
    parameter int DATA_W     = 16,
    parameter int N_SUM      = 4,
    parameter int SHIFT      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ce,
    input  logic              seed_ld,
    input  logic [63:0]       INIT_Z1,
    input  logic [63:0]       INIT_Z2,
    input  logic [63:0]       INIT_Z3,
    output logic              seed_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [15:0]       sat_cnt
);
    localparam int LN = $clog2(N_SUM);
    localparam int CW = (LN > 0) ? LN : 1;
    localparam int AW = 18 + LN;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [63:0] D1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D2 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] D3 = 64'h0F1E_2D3C_4B5A_6978;
    localparam logic [AW:0] MEAN = (AW+1)'(N_SUM * 131070);
    localparam logic signed [63:0] HI = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
    localparam logic signed [63:0] LO = -HI - 64'sd1;

    function automatic logic [63:0] taus1(input logic [63:0] z);
        return ((z & ~64'h1) << 10) ^ (((z << 24) ^ z) >> 54);
    endfunction
    function automatic logic [63:0] taus2(input logic [63:0] z);
        return ((z & ~64'h1FF) << 5) ^ (((z << 54) ^ z) >> 10);
    endfunction
    function automatic logic [63:0] taus3(input logic [63:0] z);
        return ((z & ~64'hFFF) << 29) ^ (((z << 12) ^ z) >> 52);
    endfunction

    logic [63:0] z1, z2, z3, u;
    logic u_v, res_v;
    logic [AW-1:0] acc, fin;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] res, sat_v;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW:0] wp, rp;
    logic empty, full, pop, push, run, last, b1, b2, b3;
    logic [17:0] ssum;
    logic signed [AW:0] c;
    logic signed [63:0] cx, r;

    // Handshake, stall, centring/scaling/saturation and FIFO head
    always_comb begin
        empty = wp == rp;
        full = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
        out_valid = !empty;
        pop = out_valid && out_ready;
        push = res_v && (!full || pop);
        run = ce && !(res_v && full && !pop);
        last = cnt == CW'(N_SUM - 1);
        ssum = 18'(u[15:0]) + 18'(u[31:16]) + 18'(u[47:32]) + 18'(u[63:48]);
        fin = acc + AW'(ssum);
        c = $signed({1'b0, fin}) - $signed(MEAN);
        cx = {{(63 - AW){c[AW]}}, c};
        r = cx >>> SHIFT;
        sat_v = (r > HI) ? HI[DATA_W-1:0] : (r < LO) ? LO[DATA_W-1:0] : r[DATA_W-1:0];
        data_out = empty ? '0 : mem[rp[PW-1:0]];
        b1 = INIT_Z1[63:1] == '0;
        b2 = INIT_Z2[63:9] == '0;
        b3 = INIT_Z3[63:12] == '0;
    end

    // Tausworthe state, uniform word and seed validation
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            z1 <= D1;
            z2 <= D2;
            z3 <= D3;
            u <= '0;
            u_v <= 1'b0;
            seed_err <= 1'b0;
        end else if (seed_ld) begin
            z1 <= b1 ? D1 : INIT_Z1;
            z2 <= b2 ? D2 : INIT_Z2;
            z3 <= b3 ? D3 : INIT_Z3;
            u_v <= 1'b0;
            seed_err <= b1 || b2 || b3;
        end else if (run) begin
            z1 <= taus1(z1);
            z2 <= taus2(z2);
            z3 <= taus3(z3);
            u <= taus1(z1) ^ taus2(z2) ^ taus3(z3);
            u_v <= 1'b1;
        end
    end

    // Accumulate N_SUM slice sums, then latch the saturated sample into res
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc <= '0;
            cnt <= '0;
            res <= '0;
            res_v <= 1'b0;
        end else if (seed_ld) begin
            acc <= '0;
            cnt <= '0;
            res_v <= 1'b0;
        end else begin
            if (run && u_v) begin
                acc <= last ? '0 : fin;
                cnt <= last ? '0 : cnt + CW'(1);
                if (last) res <= sat_v;
            end
            res_v <= (run && u_v && last) ? 1'b1 : push ? 1'b0 : res_v;
        end
    end

    // FIFO pointers; one extra bit separates full from empty
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp <= '0;
            rp <= '0;
        end else if (seed_ld) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + (PW+1)'(push);
            rp <= rp + (PW+1)'(pop);
        end
    end

    // FIFO storage; contents are only visible while the FIFO is non-empty
    always_ff @(posedge clk) begin
        if (push && !seed_ld) mem[wp[PW-1:0]] <= res;
    end

`ifdef GNG_CLT_SAT_CNT_EN
    logic clip;
    assign clip = (r > HI) || (r < LO);

    // Count clipped samples as they land in res, sticking at all-ones
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sat_cnt <= '0;
        else if (!seed_ld && run && u_v && last && clip && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
    end
`else
    assign sat_cnt = '0;
`endif
endmodule
